// File: rtl/i2c_pkg.sv
// Shared command codes, controller states and quarter-phase constants for the
// single-master I2C controller.
package i2c_pkg;

  localparam logic [2:0] CMD_START     = 3'd0;
  localparam logic [2:0] CMD_WRITE     = 3'd1;
  localparam logic [2:0] CMD_READ_ACK  = 3'd2;
  localparam logic [2:0] CMD_READ_NACK = 3'd3;
  localparam logic [2:0] CMD_STOP      = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WRITE,
    ST_WACK,
    ST_READ,
    ST_RACK,
    ST_STOP,
    ST_HOLD
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [3:0] LAST_DATA_BIT = 4'd7;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-bit tick generator: tick_o pulses every DIV clocks; clr_i restarts
// the count so the following quarter lasts a full DIV clocks.
module i2c_clk_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_master.sv
// Byte-level single-master I2C controller: START/WRITE/READ/STOP commands are
// serialised onto push-pull SCL and open-drain SDA, four quarters per bit.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic [7:0] tx_data,
  output logic       cmd_ready,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       ack_err,
  output logic       busy,
  output logic       SCL,
  inout  wire        SDA
);

  localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);

  if (DIV < 2) begin : g_bad_div
    $error("i2c_master: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
  end

  state_e     state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_q, rx_d;
  logic       rdnack_q, rdnack_d;
  logic       nack_q, nack_d;
  logic       ackerr_q, ackerr_d;
  logic       done_q, done_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic [1:0] sync_q;
  logic       sda_s;
  logic       tick;
  logic       accept;

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign rx_data   = rx_q;
  assign ack_err   = ackerr_q;
  assign SCL       = scl_q;
  assign SDA       = sda_q ? 1'bz : 1'b0;
  assign sda_s     = sync_q[1];

  i2c_clk_div #(
    .DIV(DIV)
  ) u_div (
    .clk_i (clk),
    .rst_ni(reset),
    .clr_i (accept),
    .tick_o(tick)
  );

  always_comb begin
    state_d  = state_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rx_d     = rx_q;
    rdnack_d = rdnack_q;
    nack_d   = nack_q;
    ackerr_d = ackerr_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          qtr_d = Q0;
          bit_d = '0;
          if (cmd == CMD_START) begin
            state_d = ST_START;
          end else if (state_q == ST_HOLD && cmd == CMD_WRITE) begin
            state_d = ST_WRITE;
            shift_d = tx_data;
          end else if (state_q == ST_HOLD &&
                       (cmd == CMD_READ_ACK || cmd == CMD_READ_NACK)) begin
            state_d  = ST_READ;
            rdnack_d = (cmd == CMD_READ_NACK);
          end else if (state_q == ST_HOLD && cmd == CMD_STOP) begin
            state_d = ST_STOP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == Q2) begin
            if (state_q == ST_WACK) nack_d = sda_s;
            if (state_q == ST_READ) shift_d = {shift_q[6:0], sda_s};
          end
          if (qtr_q == Q3) begin
            case (state_q)
              ST_WRITE: begin
                shift_d = {shift_q[6:0], 1'b0};
                bit_d   = bit_q + 4'd1;
                if (bit_q == LAST_DATA_BIT) state_d = ST_WACK;
              end
              ST_READ: begin
                bit_d = bit_q + 4'd1;
                if (bit_q == LAST_DATA_BIT) state_d = ST_RACK;
              end
              ST_WACK: begin
                state_d  = ST_HOLD;
                ackerr_d = nack_q;
                done_d   = 1'b1;
              end
              ST_RACK: begin
                state_d = ST_HOLD;
                rx_d    = shift_q;
                done_d  = 1'b1;
              end
              ST_STOP: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
              ST_START: begin
                state_d = ST_HOLD;
                done_d  = 1'b1;
              end
              default: state_d = state_q;
            endcase
          end
        end
      end
    endcase
  end

  // Bus levels decoded from the next-state values so the registered pins
  // change on the same edge as the state/quarter they belong to.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_d)
      ST_HOLD: begin
        scl_d = 1'b0;
        sda_d = sda_q;
      end
      ST_START: begin
        scl_d = (qtr_d == Q1) || (qtr_d == Q2);
        sda_d = ~qtr_d[1];
      end
      ST_WRITE: begin
        scl_d = qtr_d[1];
        sda_d = shift_d[7];
      end
      ST_WACK, ST_READ: begin
        scl_d = qtr_d[1];
        sda_d = 1'b1;
      end
      ST_RACK: begin
        scl_d = qtr_d[1];
        sda_d = rdnack_q;
      end
      ST_STOP: begin
        scl_d = (qtr_d != Q0);
        sda_d = qtr_d[1];
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      qtr_q    <= Q0;
      bit_q    <= '0;
      shift_q  <= '0;
      rx_q     <= '0;
      rdnack_q <= 1'b0;
      nack_q   <= 1'b0;
      ackerr_q <= 1'b0;
      done_q   <= 1'b0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      sync_q   <= '1;
    end else begin
      state_q  <= state_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rx_q     <= rx_d;
      rdnack_q <= rdnack_d;
      nack_q   <= nack_d;
      ackerr_q <= ackerr_d;
      done_q   <= done_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
      sync_q   <= {sync_q[0], SDA};
    end
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-master I2C bus controller that generates SCL/SDA for the board's I2C slave top level (slave registers shown on the FND/LED display). It sits directly upstream of the slave. Host logic issues byte-level commands (START, WRITE, READ with ACK/NACK, STOP) through a valid/ready handshake. The block serialises each command onto the bus and returns received data and acknowledge status.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- I2C_FREQ, 100_000, SCL frequency in Hz; localparam DIV = CLK_FREQ/(4*I2C_FREQ) clocks per quarter bit; DIV ≥ 2 (elaboration error otherwise)
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command request
- cmd  input  3  command code (see Structure)
- tx_data  input  8  byte for WRITE, captured on acceptance
- cmd_ready  output  1  high when a command can be accepted
- done  output  1  one-clock pulse at command completion
- rx_data  output  8  byte received by READ_*, updated with done
- ack_err  output  1  1 = slave NACKed last WRITE, updated with done
- busy  output  1  high whenever state ≠ IDLE
- SCL  output  1  push-pull clock (no clock stretching supported)
- SDA  inout  1  open-drain: drives 0 or 'z', external pull-up

## Operation
- Acceptance: cmd_valid & cmd_ready on a rising edge; cmd/tx_data registered; cmd_ready drops next cycle.
- States: IDLE (SCL=1, SDA released, ready=1), START, WRITE, WACK, READ, RACK, STOP, HOLD (SCL=0, SDA held, ready=1).
- Every bit = 4 quarters q0..q3, each DIV clocks. Data bits: q0/q1 SCL=0 (SDA changes at q0 start), q2/q3 SCL=1; SDA sampled at the q2→q3 boundary via 2-flop synchroniser.
- START (from IDLE or HOLD = repeated start): q0 SDA=1 SCL=0; q1 SDA=1 SCL=1; q2 SDA=0 SCL=1; q3 SDA=0 SCL=0 → HOLD.
- WRITE: 8 bits MSB first → WACK (SDA released, sample; 1 → ack_err=1) → HOLD.
- READ_ACK/READ_NACK: SDA released for 8 bits, shifted MSB first → RACK drives 0 (ACK) or releases (NACK) → HOLD.
- STOP: q0 SDA=0 SCL=0; q1 SDA=0 SCL=1; q2/q3 SDA=1 SCL=1 → IDLE.
- Illegal commands (WRITE/READ/STOP in IDLE; undefined codes anywhere): consumed, no bus activity, done pulses the cycle after acceptance, rx_data/ack_err unchanged.
- No arbitration; single-master bus.

## Timing
- Reset (reset=0, immediate): SCL=1, SDA released, cmd_ready=1, done=0, rx_data=0, ack_err=0, busy=0, state IDLE. Reset mid-byte aborts with no STOP generated.
- Quarter divider cleared on acceptance, so q0 lasts a full DIV clocks.
- Latency from acceptance edge to done: START/STOP 4·DIV clocks; WRITE/READ 36·DIV clocks. cmd_ready rises in the same cycle as done, so a back-to-back command may be accepted in the done cycle.
- busy rises the cycle after START acceptance and falls in the STOP done cycle.
- Counter width $clog2(DIV); bit counter 0..8 (9th = ack bit).

## Structure
- Package i2c_pkg: CMD_START=3'd0, CMD_WRITE=3'd1, CMD_READ_ACK=3'd2, CMD_READ_NACK=3'd3, CMD_STOP=3'd4; state encoding; quarter-phase constants.
- Sub-module i2c_clk_div: DIV-clock quarter tick generator with synchronous clear. All sequencing lives in i2c_master.

## Test plan
- Simulation parameters: CLK_FREQ=1_600_000, I2C_FREQ=100_000 (DIV=4). Checks use a slave bus model or the team's I2C slave.
- Reset: hold reset=0 → SCL=1, SDA=z, cmd_ready=1, busy=0, rx_data=0x00, ack_err=0.
- START, then WRITE 0xA0 with slave ACK → SCL rising edges see SDA 1,0,1,0,0,0,0,0; START done at 16 clocks; WRITE done at 144 clocks; ack_err=0.
- WRITE 0x7E with no slave response → ninth bit samples 1, ack_err=1, state HOLD.
- READ_NACK with slave driving 0x5C → rx_data=0x5C at done, SDA released during ninth bit. READ_ACK → SDA=0 during ninth bit.
- STOP after HOLD → SDA rises while SCL=1, done at 16 clocks, busy=0. WRITE issued in IDLE → done next cycle, no SCL toggle.
- Assert reset=0 during bit 3 of a WRITE → same clock: SCL=1, SDA=z, cmd_ready=1. New START after release works normally.
